pipe_hazard_ctrl: RTL and testbench



---
 rtl/pipe_hazard_ctrl_if.sv | 37 +++
 rtl/pipe_hazard_ctrl.sv | 118 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and pipe_hazard_ctrl.
// master = pipeline/bench side driving stage info, slave = the hazard controller.
interface pipe_hazard_ctrl_if;
  logic [4:0]  D_rs1;
  logic [4:0]  D_rs2;
  logic        D_use_rs1;
  logic        D_use_rs2;
  logic [4:0]  E_rd;
  logic [4:0]  E_op;
  logic        E_use_rd;
  logic        jb;
  logic        M_mem_req;
  logic        dmem_ready;
  logic        F_stall;
  logic        D_stall;
  logic        E_stall;
  logic        M_stall;
  logic        D_flush;
  logic        E_flush;
  logic        timeout_err;
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;

  modport master (
    output D_rs1, D_rs2, D_use_rs1, D_use_rs2, E_rd, E_op, E_use_rd, jb,
           M_mem_req, dmem_ready,
    input  F_stall, D_stall, E_stall, M_stall, D_flush, E_flush, timeout_err,
           stall_cycles, flush_count
  );

  modport slave (
    input  D_rs1, D_rs2, D_use_rs1, D_use_rs2, E_rd, E_op, E_use_rd, jb,
           M_mem_req, dmem_ready,
    output F_stall, D_stall, E_stall, M_stall, D_flush, E_flush, timeout_err,
           stall_cycles, flush_count
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline with dmem timeout trap.
// Optional perf counters enabled by defining PIPE_CTRL_PERF_EN.
module pipe_hazard_ctrl #(
  parameter logic [4:0] LOAD_OP  = 5'b00000,
  parameter int         MAX_WAIT = 16
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_WAIT - 1);

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] DWAIT = 2'd1;
  localparam logic [1:0] ERR   = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_cnt_nxt;

  logic dwait;
  logic lu;
  logic stall_all;
  logic jb_flush;
  logic lu_bubble;

  assign dwait = bus.M_mem_req && !bus.dmem_ready;
  assign lu    = (bus.E_op == LOAD_OP) && bus.E_use_rd && (bus.E_rd != 5'd0) &&
                 ((bus.D_use_rs1 && (bus.D_rs1 == bus.E_rd)) ||
                  (bus.D_use_rs2 && (bus.D_rs2 == bus.E_rd)));

  // Outputs are forced low while rst is high so a mid-wait reset releases the pipe at once.
  always_comb begin
    stall_all = 1'b0;
    jb_flush  = 1'b0;
    lu_bubble = 1'b0;
    if (!rst) begin
      if (state == ERR || dwait) stall_all = 1'b1;
      else if (bus.jb)           jb_flush  = 1'b1;
      else if (lu)               lu_bubble = 1'b1;
    end
  end

  assign bus.F_stall     = stall_all | lu_bubble;
  assign bus.D_stall     = stall_all | lu_bubble;
  assign bus.E_stall     = stall_all;
  assign bus.M_stall     = stall_all;
  assign bus.D_flush     = jb_flush;
  assign bus.E_flush     = jb_flush | lu_bubble;
  assign bus.timeout_err = (state == ERR) && !rst;

  // Counter holds the number of consecutive wait cycles already seen.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      RUN: begin
        if (dwait) begin
          wait_cnt_nxt = CNT_W'(1);
          state_nxt    = (MAX_WAIT <= 1) ? ERR : DWAIT;
        end
      end
      DWAIT: begin
        if (!dwait) begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end else begin
          wait_cnt_nxt = wait_cnt + CNT_W'(1);
          if (wait_cnt >= LAST_CNT) state_nxt = ERR;
        end
      end
      ERR: begin
        state_nxt = ERR;
      end
      default: begin
        state_nxt    = RUN;
        wait_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (bus.F_stall) stall_cnt <= sat_inc(stall_cnt);
      if (bus.E_flush) flush_cnt <= sat_inc(flush_cnt);
    end
  end

  assign bus.stall_cycles = stall_cnt;
  assign bus.flush_count  = flush_cnt;
`else
  assign bus.stall_cycles = 32'd0;
  assign bus.flush_count  = 32'd0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: vector table, directed corner sequences and a
// randomized run against a cycle-count reference model.
module tb_pipe_hazard_ctrl;
  localparam logic [4:0] LOAD_OP  = 5'b00000;
  localparam int         MAX_WAIT = 4;

  logic clk;
  logic rst;
  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl #(.LOAD_OP(LOAD_OP), .MAX_WAIT(MAX_WAIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state: consecutive wait cycles, sticky timeout, perf totals.
  int          m_wait_n;
  bit          m_err;
  logic [31:0] m_stall_n;
  logic [31:0] m_flush_n;

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] erd;
    logic [4:0] eop;
    logic       euse;
    logic       jb;
    logic       mreq;
    logic       rdy;
    logic [5:0] exp;
  } vec_t;

  vec_t tab[12];

  function automatic vec_t mk(int rs1, int rs2, int u1, int u2, int erd, int eop,
                              int euse, int jb, int mreq, int rdy, logic [5:0] exp);
    vec_t v;
    v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.u1 = 1'(u1); v.u2 = 1'(u2);
    v.erd = 5'(erd); v.eop = 5'(eop); v.euse = 1'(euse); v.jb = 1'(jb);
    v.mreq = 1'(mreq); v.rdy = 1'(rdy); v.exp = exp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input int rs1, input int rs2, input int u1, input int u2,
                        input int erd, input int eop, input int euse, input int jb,
                        input int mreq, input int rdy);
    bus.D_rs1 = 5'(rs1); bus.D_rs2 = 5'(rs2);
    bus.D_use_rs1 = 1'(u1); bus.D_use_rs2 = 1'(u2);
    bus.E_rd = 5'(erd); bus.E_op = 5'(eop); bus.E_use_rd = 1'(euse);
    bus.jb = 1'(jb); bus.M_mem_req = 1'(mreq); bus.dmem_ready = 1'(rdy);
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 5'b01100, 0, 0, 0, 1);
  endtask

  function automatic logic [5:0] act_out();
    return {bus.F_stall, bus.D_stall, bus.E_stall, bus.M_stall, bus.D_flush, bus.E_flush};
  endfunction

  // Expected {F,D,E,M stall, D,E flush, timeout_err} from the hazard rules.
  function automatic logic [6:0] ref_out();
    bit dw, hazard;
    dw = bus.M_mem_req && !bus.dmem_ready;
    hazard = (bus.E_op == LOAD_OP) && bus.E_use_rd && (bus.E_rd != 0) &&
             ((bus.D_use_rs1 && bus.D_rs1 == bus.E_rd) ||
              (bus.D_use_rs2 && bus.D_rs2 == bus.E_rd));
    if (m_err)       return 7'b1111_00_1;
    if (dw)          return 7'b1111_00_0;
    if (bus.jb)      return 7'b0000_11_0;
    if (hazard)      return 7'b1100_01_0;
    return 7'b0;
  endfunction

  function automatic logic [31:0] perf_exp(input logic [31:0] v);
`ifdef PIPE_CTRL_PERF_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  // One clock: compare at the negedge, advance the model, return just after posedge.
  task automatic cycle();
    logic [6:0] e;
    @(negedge clk);
    e = ref_out();
    chk("outputs", {act_out(), bus.timeout_err}, e);
    chk("stall_cycles", bus.stall_cycles, perf_exp(m_stall_n));
    chk("flush_count", bus.flush_count, perf_exp(m_flush_n));
    if (e[6] && m_stall_n != 32'hFFFF_FFFF) m_stall_n++;
    if (e[1] && m_flush_n != 32'hFFFF_FFFF) m_flush_n++;
    if (!m_err) begin
      if (bus.M_mem_req && !bus.dmem_ready) begin
        m_wait_n++;
        if (m_wait_n >= MAX_WAIT) m_err = 1'b1;
      end else begin
        m_wait_n = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse starting between edges; outputs must drop immediately.
  task automatic do_reset();
    #1;
    rst = 1'b1;
    #1;
    chk("rst_outputs", {act_out(), bus.timeout_err}, 7'b0);
    chk("rst_perf", {bus.stall_cycles, bus.flush_count}, 64'd0);
    m_wait_n = 0; m_err = 1'b0; m_stall_n = 0; m_flush_n = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    m_wait_n = 0; m_err = 1'b0; m_stall_n = 0; m_flush_n = 0;
    tab[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000);
    tab[1]  = mk(5, 0, 1, 0, 5, 0, 1, 0, 0, 0, 6'b110001);
    tab[2]  = mk(0, 7, 0, 1, 7, 0, 1, 0, 0, 0, 6'b110001);
    tab[3]  = mk(0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 6'b000000);
    tab[4]  = mk(5, 0, 0, 0, 5, 0, 1, 0, 0, 0, 6'b000000);
    tab[5]  = mk(5, 0, 1, 0, 5, 0, 0, 0, 0, 0, 6'b000000);
    tab[6]  = mk(5, 0, 1, 0, 5, 8, 1, 0, 0, 0, 6'b000000);
    tab[7]  = mk(5, 0, 1, 0, 5, 0, 1, 1, 0, 0, 6'b000011);
    tab[8]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 6'b000011);
    tab[9]  = mk(5, 0, 1, 0, 5, 0, 1, 0, 1, 1, 6'b110001);
    tab[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 6'b000000);
    tab[11] = mk(3, 9, 1, 1, 9, 0, 1, 0, 0, 0, 6'b110001);

    #2;
    chk("reset_outputs", {act_out(), bus.timeout_err}, 7'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single-cycle combinational vectors in RUN.
    for (int i = 0; i < 12; i++) begin
      set_in(tab[i].rs1, tab[i].rs2, tab[i].u1, tab[i].u2, tab[i].erd, tab[i].eop,
             tab[i].euse, tab[i].jb, tab[i].mreq, tab[i].rdy);
      #3;
      chk($sformatf("vec%0d", i), act_out(), tab[i].exp);
      cycle();
    end

    // 3-cycle dmem wait with jb held: flushes only once the stall drops.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 0, 0, 8, 0, 1, 1, 0);
      #3;
      chk("dwait_stall", {act_out(), bus.timeout_err}, 7'b1111_00_0);
      cycle();
    end
    set_in(0, 0, 0, 0, 0, 8, 0, 1, 1, 1);
    #3;
    chk("dwait_ready_jb", {act_out(), bus.timeout_err}, 7'b0000_11_0);
    cycle();
    idle();
    cycle();

    // Timeout: dmem never ready, ERR after the 4th wait cycle and sticky.
    do_reset();
    set_in(0, 0, 0, 0, 0, 8, 0, 0, 1, 0);
    for (int i = 0; i < MAX_WAIT; i++) begin
      #3;
      chk("pre_timeout_err", bus.timeout_err, 1'b0);
      cycle();
    end
    #3;
    chk("timeout_err", {act_out(), bus.timeout_err}, 7'b1111_00_1);
    set_in(0, 0, 0, 0, 0, 8, 0, 1, 0, 1);
    cycle();
    cycle();
    chk("err_sticky", {act_out(), bus.timeout_err}, 7'b1111_00_1);
    idle();
    do_reset();
    cycle();

    // Boundary: ready on the MAX_WAIT-th wait cycle completes normally, twice.
    for (int r = 0; r < 2; r++) begin
      set_in(0, 0, 0, 0, 0, 8, 0, 0, 1, 0);
      for (int i = 0; i < MAX_WAIT - 1; i++) cycle();
      set_in(0, 0, 0, 0, 0, 8, 0, 0, 1, 1);
      cycle();
      chk("boundary_no_err", {act_out(), bus.timeout_err}, 7'b0);
    end

    // Reset mid-wait, then a fresh wait counts from the start.
    set_in(0, 0, 0, 0, 0, 8, 0, 0, 1, 0);
    cycle();
    cycle();
    do_reset();
    for (int i = 0; i < MAX_WAIT + 1; i++) cycle();
    idle();
    do_reset();

    // Perf scenario: one load-use, 3-cycle wait, one jb.
    set_in(5, 0, 1, 0, 5, 0, 1, 0, 0, 0);
    cycle();
    set_in(0, 0, 0, 0, 0, 8, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cycle();
    set_in(0, 0, 0, 0, 0, 8, 0, 0, 1, 1);
    cycle();
    set_in(0, 0, 0, 0, 0, 8, 0, 1, 0, 0);
    cycle();
    idle();
    #2;
    chk("perf_stall_cycles", bus.stall_cycles, perf_exp(32'd4));
    chk("perf_flush_count", bus.flush_count, perf_exp(32'd2));
    cycle();

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      set_in($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
             $urandom_range(0, 1), $urandom_range(0, 3),
             ($urandom_range(0, 3) == 0) ? 5'b00100 : 5'b00000,
             $urandom_range(0, 1), ($urandom_range(0, 3) == 0) ? 1 : 0,
             $urandom_range(0, 1), ($urandom_range(0, 3) != 0) ? 1 : 0);
      if ((m_err && $urandom_range(0, 7) == 0) || $urandom_range(0, 199) == 0)
        do_reset();
      else
        cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
